// File: rtl/conv2_sram_packer.sv
// Packs BW-bit conv-stage samples into DW-bit SRAM words and writes one DP-word frame,
// then holds the frame (frame_done) until the conv2 read side acknowledges it.
`timescale 1ns/1ps

module conv2_sram_packer #(
   parameter int unsigned DW = 96,
   parameter int unsigned BW = 8,
   parameter int unsigned DP = 16,
   parameter int unsigned AW = 10
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          in_valid,
   input  logic [BW-1:0] in_data,
   output logic          in_ready,
   output logic          sram_cs,
   output logic          sram_we,
   output logic          sram_wem,
   output logic [AW-1:0] sram_addr,
   output logic [DW-1:0] sram_din,
   output logic          frame_done,
   input  logic          frame_ack
);

   localparam int unsigned L  = DW / BW;
   localparam int unsigned LW = (L > 1) ? $clog2(L) : 1;
   localparam int unsigned WW = (DP > 1) ? $clog2(DP) : 1;
   localparam logic [LW-1:0] LANE_LAST = LW'(L - 1);
   localparam logic [WW-1:0] WORD_LAST = WW'(DP - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FILL  = 2'd1,
      FLUSH = 2'd2,
      DONE  = 2'd3
   } state_e;

   state_e        state_q, state_d;
   logic [LW-1:0] lane_q,  lane_d;
   logic [WW-1:0] word_q,  word_d;
   logic [DW-1:0] pack_q,  pack_d;
   logic [DW-1:0] din_q,   din_d;
   logic [AW-1:0] addr_q,  addr_d;
   logic          wr_q,    wr_d;
   logic          accept;

   assign accept = in_valid && (state_q == FILL);

   // The completed word is copied into din_q, so pack_q is free to take lane 0 of the
   // next word in the very cycle the write pulse is on the SRAM pins.
   always_comb begin
      // NOTE: every variable gets a default first, so no path leaves one unassigned (no latch).
      state_d = state_q;
      lane_d  = lane_q;
      word_d  = word_q;
      pack_d  = pack_q;
      din_d   = din_q;
      addr_d  = addr_q;
      wr_d    = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d = FILL;
               lane_d  = '0;
               word_d  = '0;
            end
         end
         FILL: begin
            if (accept) begin
               pack_d[lane_q*BW +: BW] = in_data;
               if (lane_q == LANE_LAST) begin
                  lane_d = '0;
                  wr_d   = 1'b1;
                  din_d  = pack_d;
                  addr_d = AW'(word_q);
                  if (word_q == WORD_LAST) begin
                     state_d = FLUSH;
                     word_d  = '0;
                  end else begin
                     word_d = word_q + WW'(1);
                  end
               end else begin
                  lane_d = lane_q + LW'(1);
               end
            end
         end
         FLUSH: state_d = DONE;
         DONE: begin
            if (frame_ack) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only, so every register samples
   // the pre-edge value of every other register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         lane_q  <= '0;
         word_q  <= '0;
         // NOTE: pack_q is reset so an abandoned partial word never survives a reset;
         // functionally every lane is rewritten before a word is issued.
         pack_q  <= '0;
         din_q   <= '0;
         addr_q  <= '0;
         wr_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         lane_q  <= lane_d;
         word_q  <= word_d;
         pack_q  <= pack_d;
         din_q   <= din_d;
         addr_q  <= addr_d;
         wr_q    <= wr_d;
      end
   end

   assign in_ready   = (state_q == FILL);
   assign frame_done = (state_q == DONE);
   assign sram_cs    = wr_q;
   assign sram_we    = wr_q;
   assign sram_wem   = wr_q;
   assign sram_addr  = addr_q;
   assign sram_din   = din_q;

endmodule
